// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: operand/result handshake between the execute stage and the mul/div unit
interface mdu_sequencer_if #(parameter int XLEN = 64);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    modport slave(input in_valid, op, a, b, out_ready, output in_ready, out_valid, result);
    modport master(output in_valid, op, a, b, out_ready, input in_ready, out_valid, result);
endinterface

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV64M multiply/divide, one result bit per cycle
module mdu_sequencer #(parameter int XLEN = 64) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           flush,
    mdu_sequencer_if.slave bus,
    output logic           busy
);
    localparam int H = XLEN / 2;
    localparam int CW = $clog2(XLEN);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIXUP, DONE} stateT;
    stateT state, stateNext;
    logic [XLEN-1:0] opA, opB, acc, rem, aSext, bSext, aRaw, bRaw, aMag, bMag, minVal;
    logic [XLEN-1:0] specialRes, resVal, fixed;
    logic [XLEN:0] remShift, diff;
    logic [CW-1:0] cnt;
    logic isW, isMul, isRem, negQ, negR;
    logic opW, opSigned, opRem, opMul, opUnused, aNeg, bNeg, bZero, ovf, special;
    logic accept, last, geq;
    assign opW = bus.op >= 4'd5 && bus.op <= 4'd9;
    assign opSigned = bus.op == 4'd1 || bus.op == 4'd3 || bus.op == 4'd6 || bus.op == 4'd8;
    assign opRem = bus.op == 4'd3 || bus.op == 4'd4 || bus.op == 4'd8 || bus.op == 4'd9;
    assign opMul = bus.op == 4'd0 || bus.op == 4'd5;
    assign opUnused = bus.op > 4'd9;
    assign aSext = opW ? {{H{bus.a[H-1]}}, bus.a[H-1:0]} : bus.a;
    assign bSext = opW ? {{H{bus.b[H-1]}}, bus.b[H-1:0]} : bus.b;
    assign aRaw = opW ? {{H{1'b0}}, bus.a[H-1:0]} : bus.a;
    assign bRaw = opW ? {{H{1'b0}}, bus.b[H-1:0]} : bus.b;
    assign aNeg = opSigned && aSext[XLEN-1];
    assign bNeg = opSigned && bSext[XLEN-1];
    assign aMag = aNeg ? -aSext : aRaw;
    assign bMag = bNeg ? -bSext : bRaw;
    assign minVal = opW ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    assign bZero = bSext == '0;
    assign ovf = opSigned && bSext == '1 && aSext == minVal;
    assign special = !opMul && !opUnused && (bZero || ovf);
    // Both special-case quotients (all ones, MIN) and remainders (dividend, 0) come straight from the operands
    assign specialRes = opUnused ? '0 : bZero ? (opRem ? aSext : '1) : (opRem ? '0 : aSext);
    assign accept = bus.in_valid && state == IDLE && !flush;
    assign last = cnt == (isW ? CW'(H - 1) : CW'(XLEN - 1));
    assign remShift = {rem, isW ? opA[H-1] : opA[XLEN-1]};
    assign diff = remShift - {1'b0, opB};
    assign geq = !diff[XLEN];
    assign resVal = isMul ? acc : isRem ? rem : opA;
    assign fixed = (isRem ? negR : negQ) ? -resVal : resVal;
    assign bus.in_ready = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= IDLE;
        else state <= stateNext;
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept) stateNext = (opUnused || special) ? DONE : opMul ? MUL : DIV;
            MUL, DIV: if (last) stateNext = FIXUP;
            FIXUP: stateNext = DONE;
            DONE: if (bus.out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (flush) stateNext = IDLE;
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            opA <= '0;
            opB <= '0;
            acc <= '0;
            rem <= '0;
            cnt <= '0;
            isW <= 1'b0;
            isMul <= 1'b0;
            isRem <= 1'b0;
            negQ <= 1'b0;
            negR <= 1'b0;
            bus.result <= '0;
        end else if (accept) begin
            opA <= aMag;
            opB <= bMag;
            acc <= '0;
            rem <= '0;
            cnt <= '0;
            isW <= opW;
            isMul <= opMul;
            isRem <= opRem;
            negQ <= aNeg ^ bNeg;
            negR <= aNeg;
            bus.result <= specialRes;
        end else if (state == MUL) begin
            acc <= acc + (opB[0] ? opA : '0);
            opA <= opA << 1;
            opB <= opB >> 1;
            cnt <= cnt + 1'b1;
        end else if (state == DIV) begin
            rem <= geq ? diff[XLEN-1:0] : remShift[XLEN-1:0];
            opA <= {opA[XLEN-2:0], geq};
            cnt <= cnt + 1'b1;
        end else if (state == FIXUP && !flush) begin
            bus.result <= isW ? {{H{fixed[H-1]}}, fixed[H-1:0]} : fixed;
        end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed vectors, randomized ops vs arithmetic model, flush/reset/backpressure sequences
module tb_mdu_sequencer;
    localparam logic [63:0] MIN64 = 64'h8000000000000000;
    logic clk = 0, resetn = 0, flush = 0, busy;
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    mdu_sequencer_if #(.XLEN(64)) bus();
    mdu_sequencer #(.XLEN(64)) dut(.clk(clk), .resetn(resetn), .flush(flush), .bus(bus), .busy(busy));
    typedef struct {logic [3:0] op; logic [63:0] a; logic [63:0] b; logic [63:0] res; int lat;} vecT;
    vecT vecs[12];
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        longint sa, sb;
        int ia, ib;
        logic [31:0] aw, bw, rw;
        sa = a; sb = b; aw = a[31:0]; bw = b[31:0]; ia = aw; ib = bw; rw = 0;
        case (op)
            0: return a * b;
            1: return b == 0 ? '1 : (a == MIN64 && b == '1) ? MIN64 : 64'(sa / sb);
            2: return b == 0 ? '1 : a / b;
            3: return b == 0 ? a : (a == MIN64 && b == '1) ? 64'd0 : 64'(sa % sb);
            4: return b == 0 ? a : a % b;
            5: rw = aw * bw;
            6: rw = bw == 0 ? '1 : (aw == 32'h80000000 && bw == '1) ? aw : 32'(ia / ib);
            7: rw = bw == 0 ? '1 : aw / bw;
            8: rw = bw == 0 ? aw : (aw == 32'h80000000 && bw == '1) ? 32'd0 : 32'(ia % ib);
            9: rw = bw == 0 ? aw : aw % bw;
            default: return 64'd0;
        endcase
        return {{32{rw[31]}}, rw};
    endfunction
    // Edges after the accept edge until out_valid is seen
    function automatic int modelLat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic w, sgn, bz, ov;
        if (op > 9) return 0;
        w = op >= 5;
        if (op == 0 || op == 5) return w ? 33 : 65;
        sgn = op == 1 || op == 3 || op == 6 || op == 8;
        bz = w ? b[31:0] == 0 : b == 0;
        ov = sgn && (w ? (a[31:0] == 32'h80000000 && b[31:0] == '1) : (a == MIN64 && b == '1));
        return (bz || ov) ? 0 : (w ? 33 : 65);
    endfunction
    task automatic runOp(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat);
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1;
        @(posedge clk); #1;
        bus.in_valid = 0; bus.a = ~a; bus.b = a ^ b;
        lat = -1;
        for (int k = 0; k <= 200; k++) begin
            if (bus.out_valid) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        res = bus.result;
    endtask
    task automatic takeResult();
        bus.out_ready = 1;
        @(posedge clk); #1;
        bus.out_ready = 0;
    endtask
    function automatic logic [63:0] randOperand();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return '1;
            2: return MIN64;
            3: return 64'($urandom_range(0, 50));
            4: return {32'hFFFFFFFF, 32'h80000000};
            default: return {$urandom, $urandom};
        endcase
    endfunction
    initial begin
        logic [63:0] res, held;
        int lat;
        logic seen;
        vecs[0]  = '{4'd0, 64'd3, -64'd5, 64'hFFFFFFFFFFFFFFF1, 65};
        vecs[1]  = '{4'd1, -64'd7, 64'd2, -64'd3, 65};
        vecs[2]  = '{4'd3, -64'd7, 64'd2, '1, 65};
        vecs[3]  = '{4'd5, 64'h7FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, 33};
        vecs[4]  = '{4'd2, 64'd5, 64'd0, '1, 0};
        vecs[5]  = '{4'd4, 64'd5, 64'd0, 64'd5, 0};
        vecs[6]  = '{4'd1, MIN64, '1, MIN64, 0};
        vecs[7]  = '{4'd3, MIN64, '1, 64'd0, 0};
        vecs[8]  = '{4'd6, 64'h80000000, '1, 64'hFFFFFFFF80000000, 0};
        vecs[9]  = '{4'd12, 64'd9, 64'd4, 64'd0, 0};
        vecs[10] = '{4'd7, 64'hFFFFFFFF00000007, 64'd2, 64'd3, 33};
        vecs[11] = '{4'd8, -64'd7, 64'd2, '1, 33};
        bus.in_valid = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 64'(bus.out_valid), 0);
        check("reset result", bus.result, 0);
        check("reset busy", 64'(busy), 0);
        check("reset in_ready", 64'(bus.in_ready), 1);
        resetn = 1;
        @(posedge clk); #1;
        foreach (vecs[i]) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d result", i), res, vecs[i].res);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d in_ready in DONE", i), 64'(bus.in_ready), 0);
            takeResult();
            check($sformatf("vec%0d released", i), 64'(bus.in_ready && !bus.out_valid), 1);
        end
        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            logic [63:0] a, b;
            op = 4'($urandom_range(0, 15));
            a = randOperand();
            b = randOperand();
            runOp(op, a, b, res, lat);
            check($sformatf("rand%0d op%0d result", i, op), res, model(op, a, b));
            check($sformatf("rand%0d op%0d latency", i, op), 64'(lat), 64'(modelLat(op, a, b)));
            takeResult();
        end
        runOp(4'd2, 64'd100, 64'd7, held, lat);
        check("bp result", held, 64'd14);
        bus.in_valid = 1; bus.op = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp out_valid", 64'(bus.out_valid), 1);
            check("bp result stable", bus.result, held);
            check("bp in_ready", 64'(bus.in_ready), 0);
        end
        bus.in_valid = 0;
        takeResult();
        check("bp no stray accept", 64'(busy), 0);
        bus.op = 4'd1; bus.a = 64'd1000; bus.b = 64'd3; bus.in_valid = 1;
        @(posedge clk); #1;
        bus.in_valid = 0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        check("flush busy", 64'(busy), 0);
        check("flush in_ready", 64'(bus.in_ready), 1);
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            seen |= bus.out_valid;
            @(posedge clk); #1;
        end
        check("flush never out_valid", 64'(seen), 0);
        bus.op = 4'd0; bus.a = 64'd2; bus.b = 64'd2; bus.in_valid = 1; flush = 1;
        @(posedge clk); #1;
        bus.in_valid = 0; flush = 0;
        check("flush blocks accept", 64'(busy), 0);
        runOp(4'd4, 64'd5, 64'd0, res, lat);
        check("done-flush pre result", res, 64'd5);
        flush = 1; bus.out_ready = 1;
        @(posedge clk); #1;
        flush = 0; bus.out_ready = 0;
        check("done-flush idle", 64'(bus.in_ready && !bus.out_valid), 1);
        bus.op = 4'd0; bus.a = 64'd123; bus.b = 64'd456; bus.in_valid = 1;
        @(posedge clk); #1;
        bus.in_valid = 0;
        repeat (20) @(posedge clk);
        #2;
        resetn = 0;
        #1;
        check("rst out_valid", 64'(bus.out_valid), 0);
        check("rst result", bus.result, 0);
        check("rst busy", 64'(busy), 0);
        @(posedge clk); #1;
        resetn = 1;
        seen = 0;
        for (int k = 0; k < 70; k++) begin
            seen |= bus.out_valid;
            @(posedge clk); #1;
        end
        check("rst op dropped", 64'(seen), 0);
        runOp(4'd0, 64'd6, 64'd7, res, lat);
        check("post-rst result", res, 64'd42);
        check("post-rst latency", 64'(lat), 64'd65);
        takeResult();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
